// File: rtl/hub75_fb_arbiter_pkg.sv
// Shared encodings for the hub75 frame-buffer SPRAM arbiter: owner codes and FSM states.
package hub75_fb_arbiter_pkg;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_RD   = 2'd1;
    localparam logic [1:0] OWN_WR   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_OWN = 2'd1,
        ST_WR_OWN = 2'd2,
        ST_TURN   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/hub75_fb_arbiter.sv
// Two-client req/gnt/rel arbiter for the single-port frame-buffer SPRAM.
// Read-out wins ties; a defer counter caps how many reads may overtake a pending write.
module hub75_fb_arbiter
    import hub75_fb_arbiter_pkg::*;
#(
    parameter int FB_AW        = 13,
    parameter int FB_DW        = 16,
    parameter int WR_MAX_DEFER = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_rd_req,
    output logic             o_rd_gnt,
    input  logic             i_rd_rel,
    input  logic [FB_AW-1:0] i_rd_addr,
    output logic [FB_DW-1:0] o_rd_data,
    input  logic             i_wr_req,
    output logic             o_wr_gnt,
    input  logic             i_wr_rel,
    input  logic [FB_AW-1:0] i_wr_addr,
    input  logic [FB_DW-1:0] i_wr_data,
    input  logic             i_wr_wren,
    output logic [FB_AW-1:0] o_mem_addr,
    output logic [FB_DW-1:0] o_mem_wdata,
    output logic             o_mem_wren,
    input  logic [FB_DW-1:0] i_mem_rdata,
    output logic             o_busy,
    output logic             o_err
);

    localparam int              DCW       = $clog2(WR_MAX_DEFER + 1);
    localparam logic [DCW-1:0]  DEFER_MAX = DCW'(WR_MAX_DEFER);

    arb_state_t     r_state;
    arb_state_t     w_state_nxt;
    logic [1:0]     r_owner;
    logic [DCW-1:0] r_defer_cnt;
    logic           r_rd_gnt;
    logic           r_wr_gnt;
    logic           r_err;
    logic           w_rd_grant;
    logic           w_wr_grant;
    logic           w_rel_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_grant  = 1'b0;
        w_wr_grant  = 1'b0;
        // Owner is NONE in IDLE, so any rel there counts as a non-owner rel.
        w_rel_err   = (i_rd_rel && (r_owner != OWN_RD)) ||
                      (i_wr_rel && (r_owner != OWN_WR));
        case (r_state)
            ST_IDLE: begin
                if (i_wr_req && (r_defer_cnt == DEFER_MAX)) begin
                    w_wr_grant  = 1'b1;
                    w_state_nxt = ST_WR_OWN;
                end else if (i_rd_req) begin
                    w_rd_grant  = 1'b1;
                    w_state_nxt = ST_RD_OWN;
                end else if (i_wr_req) begin
                    w_wr_grant  = 1'b1;
                    w_state_nxt = ST_WR_OWN;
                end
            end
            ST_RD_OWN: if (i_rd_rel) w_state_nxt = ST_TURN;
            ST_WR_OWN: if (i_wr_rel) w_state_nxt = ST_TURN;
            ST_TURN:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Owner persists through TURN so a client's last registered write still lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner     <= OWN_NONE;
            r_rd_gnt    <= 1'b0;
            r_wr_gnt    <= 1'b0;
            r_defer_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            r_rd_gnt <= w_rd_grant;
            r_wr_gnt <= w_wr_grant;
            r_err    <= r_err | w_rel_err;
            if (w_rd_grant)              r_owner <= OWN_RD;
            else if (w_wr_grant)         r_owner <= OWN_WR;
            else if (r_state == ST_TURN) r_owner <= OWN_NONE;
            if (w_wr_grant)
                r_defer_cnt <= '0;
            else if (w_rd_grant && i_wr_req && (r_defer_cnt != DEFER_MAX))
                r_defer_cnt <= r_defer_cnt + 1'b1;
        end
    end

    always_comb begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_wren  = 1'b0;
        case (r_owner)
            OWN_RD: o_mem_addr = i_rd_addr;
            OWN_WR: begin
                o_mem_addr  = i_wr_addr;
                o_mem_wdata = i_wr_data;
                o_mem_wren  = i_wr_wren;
            end
            default: ;
        endcase
    end

    assign o_rd_gnt  = r_rd_gnt;
    assign o_wr_gnt  = r_wr_gnt;
    assign o_rd_data = i_mem_rdata;
    assign o_busy    = (r_state != ST_IDLE);
    assign o_err     = r_err;

endmodule
